// File: rtl/dp_data_mem_pkg.sv
// Shared constants, FSM encoding and lane helpers for the dual-port data memory.
package dp_mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0] word;
    logic [3:0]  be;
  } merge_t;

  // Half needs an even address, word needs a 4-byte aligned address, size 11 never succeeds.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = lane[0];
      SZ_W:    bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Pull the addressed little-endian lane(s) out of a word and extend to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      SZ_B:    r = {{24{b[7] & ~uns}}, b};
      SZ_H:    r = {{16{h[15] & ~uns}}, h};
      SZ_W:    r = word;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Place right-aligned store data into its lanes; untouched bytes keep the old value.
  function automatic merge_t store_merge(input logic [31:0] old, input logic [31:0] wdata,
                                         input logic [1:0] size, input logic [1:0] lane);
    merge_t m;
    m.word = old;
    case (size)
      SZ_B: begin
        m.be = 4'b0001 << lane;
        m.word[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_H: begin
        m.be = lane[1] ? 4'b1100 : 4'b0011;
        m.word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      end
      SZ_W: begin
        m.be   = 4'b1111;
        m.word = wdata;
      end
      default: begin
        m.be = 4'b0000;
      end
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dp_data_mem_if.sv
// Per-port load/store request and response bundle; master drives requests, slave is the memory.
interface dp_data_mem_if #(parameter int ADDR_W = 10) ();
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              unsgn;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              ready;
  logic              rvalid;
  logic [31:0]       rdata;
  logic              misalign;

  modport master (
    output req, we, size, unsgn, addr, wdata,
    input  ready, rvalid, rdata, misalign
  );

  modport slave (
    input  req, we, size, unsgn, addr, wdata,
    output ready, rvalid, rdata, misalign
  );
endinterface

// File: rtl/dp_data_mem_port.sv
// One access port: request decode, alignment check, store merge and registered response.
module dp_mem_port
  import dp_mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              allow,
  input  logic [31:0]       rd_word,
  output logic [ADDR_W-3:0] idx,
  output logic              wr_en,
  output logic [31:0]       wr_word,
  output logic [3:0]        wr_be,
  dp_data_mem_if.slave      p
);

  logic        accept_s;
  logic        fault_s;
  merge_t      merge_s;
  logic        rvalid_r;
  logic        misalign_r;
  logic [31:0] rdata_r;

  assign p.ready  = allow;
  assign accept_s = p.req & allow;
  assign fault_s  = is_misaligned(p.size, p.addr[1:0]);
  assign idx      = p.addr[ADDR_W-1:2];
  assign merge_s  = store_merge(rd_word, p.wdata, p.size, p.addr[1:0]);
  assign wr_en    = accept_s & p.we & ~fault_s;
  assign wr_word  = merge_s.word;
  assign wr_be    = merge_s.be;

  // Response registers: one pulse per accepted request; reset drops anything in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid_r   <= 1'b0;
      misalign_r <= 1'b0;
      rdata_r    <= 32'h0000_0000;
    end else begin
      rvalid_r   <= accept_s;
      misalign_r <= accept_s & fault_s;
      if (accept_s && !p.we && !fault_s) begin
        rdata_r <= load_extend(rd_word, p.size, p.addr[1:0], p.unsgn);
      end else begin
        rdata_r <= 32'h0000_0000;
      end
    end
  end

  assign p.rvalid   = rvalid_r;
  assign p.misalign = misalign_r;
  assign p.rdata    = rdata_r;

endmodule

// File: rtl/dp_data_mem.sv
// Dual-port byte-addressed data memory: byte-lane storage, post-reset clear sweep and
// same-word arbitration where port A always wins.
module dp_data_mem
  import dp_mem_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  output logic         busy,
  dp_data_mem_if.slave a,
  dp_data_mem_if.slave b
);

  localparam int     IW          = ADDR_W - 2;
  localparam int     WORDS       = 2 ** IW;
  localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  state_t          state_r;
  logic [IW-1:0]   clr_cnt_r;
  logic            run_s;
  logic            clr_we_s;
  logic            conflict_s;
  logic            a_allow_s;
  logic            b_allow_s;
  logic [IW-1:0]   a_idx_s;
  logic [IW-1:0]   b_idx_s;
  logic            a_wr_en_s;
  logic            b_wr_en_s;
  logic [31:0]     a_wword_s;
  logic [31:0]     b_wword_s;
  logic [3:0]      a_be_s;
  logic [3:0]      b_be_s;
  logic [31:0]     a_rd_s;
  logic [31:0]     b_rd_s;

  // Clear FSM: sweep one word per cycle from word 0, then serve requests.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= RESET_STATE;
      clr_cnt_r <= '0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          if (&clr_cnt_r) begin
            state_r   <= ST_RUN;
            clr_cnt_r <= '0;
          end else begin
            clr_cnt_r <= clr_cnt_r + IW'(1);
          end
        end
        ST_RUN: begin
          state_r <= ST_RUN;
        end
        default: begin
          state_r   <= RESET_STATE;
          clr_cnt_r <= '0;
        end
      endcase
    end
  end

  assign busy     = (state_r == ST_CLEAR);
  assign clr_we_s = rst & (state_r == ST_CLEAR);
  assign run_s    = rst & (state_r == ST_RUN);

  // B backs off only when both ports touch the same word and at least one of them stores.
  assign conflict_s = a.req & b.req & (a_idx_s == b_idx_s) & (a.we | b.we);
  assign a_allow_s  = run_s;
  assign b_allow_s  = run_s & ~conflict_s;

  dp_mem_port #(.ADDR_W(ADDR_W)) u_port_a (
    .clk     (clk),
    .rst     (rst),
    .allow   (a_allow_s),
    .rd_word (a_rd_s),
    .idx     (a_idx_s),
    .wr_en   (a_wr_en_s),
    .wr_word (a_wword_s),
    .wr_be   (a_be_s),
    .p       (a)
  );

  dp_mem_port #(.ADDR_W(ADDR_W)) u_port_b (
    .clk     (clk),
    .rst     (rst),
    .allow   (b_allow_s),
    .rd_word (b_rd_s),
    .idx     (b_idx_s),
    .wr_en   (b_wr_en_s),
    .wr_word (b_wword_s),
    .wr_be   (b_be_s),
    .p       (b)
  );

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] bank_r [WORDS];

    // Byte lane g: clear sweep has priority, else each port writes its enabled byte.
    always_ff @(posedge clk) begin
      if (clr_we_s) begin
        bank_r[clr_cnt_r] <= 8'h00;
      end else begin
        if (a_wr_en_s && a_be_s[g]) begin
          bank_r[a_idx_s] <= a_wword_s[8*g +: 8];
        end
        if (b_wr_en_s && b_be_s[g]) begin
          bank_r[b_idx_s] <= b_wword_s[8*g +: 8];
        end
      end
    end

    assign a_rd_s[8*g +: 8] = bank_r[a_idx_s];
    assign b_rd_s[8*g +: 8] = bank_r[b_idx_s];
  end

endmodule

// File: doc/dp_data_mem.md
# dp_data_mem

Parametrised dual-port, byte-addressed data memory for the core's load/store path: next generation of the current 1 KiB byte/half/word BRAM. Adds generic depth, byte-lane writes with correct little-endian packing, signed/unsigned load extension, per-port request/ready handshake with registered read response, deterministic same-word arbitration, misalignment flagging and a post-reset clear sweep. Port A serves the data stage; port B serves the second agent (debug/DMA).

## Interface
- ADDR_W, 10, byte-address width; capacity 2^ADDR_W bytes, stored as 2^(ADDR_W-2) 32-bit words; ADDR_W >= 3.
- CLEAR_ON_RESET, 1, 1 = zero all words after reset; 0 = skip the sweep, contents undefined.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- busy  out  1  high while the clear sweep runs.
- For each port p in {a, b}:
- p_req  in  1  request valid.
- p_we  in  1  1 = store, 0 = load.
- p_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- p_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- p_addr  in  ADDR_W  byte address.
- p_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- p_ready  out  1  request accepted this cycle when p_req && p_ready.
- p_rvalid  out  1  one-cycle pulse: response for the request accepted the previous cycle.
- p_rdata  out  32  load result, extended; 0 for stores and faulted requests.
- p_misalign  out  1  qualifies p_rvalid: accepted request was misaligned or illegal.

## Operation
- FSM states CLEAR and RUN. Reset enters CLEAR if CLEAR_ON_RESET, else RUN.
- CLEAR: word counter from 0 to 2^(ADDR_W-2)-1, one zero word per cycle; after the last word, RUN. busy = 1, both readies = 0.
- RUN: a_ready = 1. b_ready = 0 only when a_req && b_req, both word indices (addr[ADDR_W-1:2]) are equal, and a_we || b_we. Otherwise b_ready = 1. A always wins; B holds its request and retries.
- Alignment: half needs addr[0] = 0; word needs addr[1:0] = 00; size 11 always faults. A faulted request is accepted, has no memory effect, and returns rvalid = 1, misalign = 1, rdata = 0.
- Store lanes are little-endian:
  - byte writes lane addr[1:0];
  - half writes bytes 2*addr[1] and 2*addr[1]+1;
  - word writes all four.
  - Untouched bytes are preserved.
- Load extracts the same lanes, then zero- or sign-extends to 32 bits per p_unsigned.
- Non-conflicting A and B accesses, including two stores to different words, complete in the same cycle.
- Two loads to the same word are not a conflict and proceed together.

## Timing
- Load latency is 1: request accepted in cycle n gives rvalid/rdata in n+1. Back-to-back requests give one response per cycle.
- Store commits at the accepting edge. A load accepted in n+1 returns the stored value.
- p_ready is combinational from FSM state and the inputs. It is forced to 0 while rst is low.
- Reset values: p_ready 0, p_rvalid 0, p_rdata 0, p_misalign 0, busy = CLEAR_ON_RESET.
- Reset asserted mid-operation:
  - any in-flight response is dropped;
  - a store already committed remains;
  - the clear sweep restarts from word 0.
- The sweep lasts exactly 2^(ADDR_W-2) cycles after reset deassertion. ready rises the cycle after the last clear write.

## Structure
- Package dp_mem_pkg holds:
  - size constants SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10;
  - FSM state encoding;
  - function is_misaligned(size, addr[1:0]);
  - function load_extend(word, size, lane, unsigned);
  - function store_merge(old, wdata, size, lane) returning the new word and byte enables.
- Sub-module dp_mem_port, instantiated twice: request decode, alignment check, response/rdata registers. Top level holds the storage array, the clear FSM and arbitration.

## Test plan
- Reset with CLEAR_ON_RESET = 1, ADDR_W = 10 -> busy high for exactly 256 cycles, readies low, then a word load from 0x3FC returns 0x00000000.
- A: word store 0x80FF7F01 to 0x010, then byte loads at 0x011 -> 0x0000007F (unsigned) and 0x013 -> 0xFFFFFF80 (signed), then half signed load at 0x010 -> 0x00007F01.
- A: half store 0xBEEF to 0x012 over word 0x11223344 -> a word load at 0x010 returns 0xBEEF3344.
- Same cycle: A stores a word to 0x020, B loads 0x022 -> b_ready = 0 for one cycle. B is accepted next cycle and returns A's data.
- A: word load at 0x001 and size 11 at 0x004 -> each gives rvalid = 1, misalign = 1, rdata = 0, and memory is unchanged.
- Assert rst for 2 cycles mid-burst of pipelined loads -> rvalid drops immediately, busy rises, the sweep restarts from word 0.
